fc_mem: RTL and testbench

FC_MEM -- requirements
Module: fc_mem

---
 rtl/fc_mem.sv | 160 ++++++++++++++++
 tb/tb_fc_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_mem.sv
// fc_mem: two signed weight banks plus two bias registers behind a config
// read/write port, and a ready/valid stream that walks both weight banks in
// lockstep, emitting {weight1[idx], weight0[idx]} per beat.
module fc_mem #(
    parameter int FC_BANK_BW = 2,
    parameter int FC_ADDR_BW = 8,
    parameter int FC_BIAS_BW = 32,
    parameter int WEIGHT_BW  = 8,
    parameter int N_WEIGHTS  = 208
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   fc_rd_en_i,
    input  logic                   fc_wr_en_i,
    input  logic [FC_BANK_BW-1:0]  fc_rd_wr_bank_i,
    input  logic [FC_ADDR_BW-1:0]  fc_rd_wr_addr_i,
    input  logic [FC_BIAS_BW-1:0]  fc_wr_data_i,
    output logic [FC_BIAS_BW-1:0]  fc_rd_data_o,
    input  logic                   start_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [2*WEIGHT_BW-1:0] data_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic [FC_BIAS_BW-1:0]  bias0_o,
    output logic [FC_BIAS_BW-1:0]  bias1_o
);

    typedef enum logic [0:0] {IDLE, STREAM} state_t;

    localparam logic [FC_BANK_BW-1:0] BANK_W0 = FC_BANK_BW'(0);
    localparam logic [FC_BANK_BW-1:0] BANK_W1 = FC_BANK_BW'(1);
    localparam logic [FC_BANK_BW-1:0] BANK_B0 = FC_BANK_BW'(2);
    localparam logic [FC_BANK_BW-1:0] BANK_B1 = FC_BANK_BW'(3);
    localparam logic [FC_ADDR_BW-1:0] LAST_IDX = FC_ADDR_BW'(N_WEIGHTS - 1);

    // Weight memories carry no reset so their contents survive rst_n_i.
    logic signed [WEIGHT_BW-1:0] weight0_mem [N_WEIGHTS];
    logic signed [WEIGHT_BW-1:0] weight1_mem [N_WEIGHTS];

    logic [FC_BIAS_BW-1:0] bias0_q, bias0_d;
    logic [FC_BIAS_BW-1:0] bias1_q, bias1_d;
    logic [FC_BIAS_BW-1:0] rd_data_q, rd_data_d;
    logic [FC_BIAS_BW-1:0] rd_word;
    state_t                state_q, state_d;
    logic [FC_ADDR_BW-1:0] idx_q, idx_d;

    logic addr_in_w;
    logic addr_is_0;
    logic idx_in_w;
    logic stream_valid;
    logic stream_last;

    function automatic logic [FC_BIAS_BW-1:0] sext_weight(input logic signed [WEIGHT_BW-1:0] w);
        return {{(FC_BIAS_BW-WEIGHT_BW){w[WEIGHT_BW-1]}}, w};
    endfunction

    assign addr_in_w = (32'(fc_rd_wr_addr_i) < N_WEIGHTS);
    assign addr_is_0 = (fc_rd_wr_addr_i == '0);
    assign idx_in_w  = (32'(idx_q) < N_WEIGHTS);

    // Config writes into the weight banks; out-of-range addresses are dropped.
    always_ff @(posedge clk_i) begin
        if (fc_wr_en_i && addr_in_w) begin
            if (fc_rd_wr_bank_i == BANK_W0) begin
                weight0_mem[fc_rd_wr_addr_i] <= fc_wr_data_i[WEIGHT_BW-1:0];
            end
            if (fc_rd_wr_bank_i == BANK_W1) begin
                weight1_mem[fc_rd_wr_addr_i] <= fc_wr_data_i[WEIGHT_BW-1:0];
            end
        end
    end

    // Bias registers take the full word, only at address 0.
    always_comb begin
        bias0_d = bias0_q;
        bias1_d = bias1_q;
        if (fc_wr_en_i && addr_is_0) begin
            if (fc_rd_wr_bank_i == BANK_B0) bias0_d = fc_wr_data_i;
            if (fc_rd_wr_bank_i == BANK_B1) bias1_d = fc_wr_data_i;
        end
    end

    // Config read mux: weights sign-extended, anything out of range reads 0.
    always_comb begin
        rd_word = '0;
        case (fc_rd_wr_bank_i)
            BANK_W0: if (addr_in_w) rd_word = sext_weight(weight0_mem[fc_rd_wr_addr_i]);
            BANK_W1: if (addr_in_w) rd_word = sext_weight(weight1_mem[fc_rd_wr_addr_i]);
            BANK_B0: if (addr_is_0) rd_word = bias0_q;
            BANK_B1: if (addr_is_0) rd_word = bias1_q;
            default: rd_word = '0;
        endcase
    end

    // Read data register loads only on a read strobe and holds otherwise; it
    // samples pre-edge storage, so a same-cycle write is not yet visible.
    always_comb begin
        rd_data_d = rd_data_q;
        if (fc_rd_en_i) rd_data_d = rd_word;
    end

    // Stream FSM: a config access in either direction stalls the beat.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        stream_valid = 1'b0;
        stream_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                stream_valid = !(fc_rd_en_i || fc_wr_en_i);
                stream_last  = stream_valid && (idx_q == LAST_IDX);
                if (stream_valid && ready_i) begin
                    if (stream_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Control and bias state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rd_data_q <= '0;
            bias0_q   <= '0;
            bias1_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
            bias0_q   <= bias0_d;
            bias1_q   <= bias1_d;
        end
    end

    assign fc_rd_data_o = rd_data_q;
    assign bias0_o      = bias0_q;
    assign bias1_o      = bias1_q;
    assign busy_o       = (state_q == STREAM);
    assign valid_o      = stream_valid;
    assign last_o       = stream_last;
    assign data_o       = idx_in_w ? {weight1_mem[idx_q], weight0_mem[idx_q]} : '0;

endmodule

// File: tb/tb_fc_mem.sv
// Directed bench for fc_mem: config vector table, then full, stalled and
// reset-interrupted weight streams.
module tb_fc_mem;

    localparam int NW = 208;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        fc_rd_en_i, fc_wr_en_i;
    logic [1:0]  fc_rd_wr_bank_i;
    logic [7:0]  fc_rd_wr_addr_i;
    logic [31:0] fc_wr_data_i;
    logic [31:0] fc_rd_data_o;
    logic        start_i, ready_i;
    logic        valid_o, last_o, busy_o;
    logic [15:0] data_o;
    logic [31:0] bias0_o, bias1_o;

    int n_vec = 0;
    int n_bad = 0;

    fc_mem dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .fc_rd_en_i(fc_rd_en_i), .fc_wr_en_i(fc_wr_en_i),
        .fc_rd_wr_bank_i(fc_rd_wr_bank_i), .fc_rd_wr_addr_i(fc_rd_wr_addr_i),
        .fc_wr_data_i(fc_wr_data_i), .fc_rd_data_o(fc_rd_data_o),
        .start_i(start_i), .ready_i(ready_i), .valid_o(valid_o),
        .data_o(data_o), .last_o(last_o), .busy_o(busy_o),
        .bias0_o(bias0_o), .bias1_o(bias1_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  bank;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_b0;
        logic [31:0] exp_b1;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cfg_idle();
        fc_rd_en_i = 1'b0;
        fc_wr_en_i = 1'b0;
        fc_rd_wr_bank_i = '0;
        fc_rd_wr_addr_i = '0;
        fc_wr_data_i = '0;
    endtask

    task automatic cfg_write(input logic [1:0] bank, input logic [7:0] addr, input logic [31:0] d);
        @(negedge clk_i);
        fc_wr_en_i = 1'b1; fc_rd_en_i = 1'b0;
        fc_rd_wr_bank_i = bank; fc_rd_wr_addr_i = addr; fc_wr_data_i = d;
        @(negedge clk_i);
        cfg_idle();
    endtask

    task automatic cfg_read_check(input string name, input logic [1:0] bank,
                                  input logic [7:0] addr, input logic [31:0] exp);
        @(negedge clk_i);
        fc_rd_en_i = 1'b1; fc_wr_en_i = 1'b0;
        fc_rd_wr_bank_i = bank; fc_rd_wr_addr_i = addr;
        @(posedge clk_i);
        #1;
        check(name, fc_rd_data_o, exp);
        @(negedge clk_i);
        cfg_idle();
    endtask

    // mode 0: ready held high; mode 1: random ready, config reads, stray starts.
    // stop_at >= 0 returns early after that many transfers.
    task automatic run_stream(input int mode, input int stop_at, output int got);
        int k;
        int cyc;
        logic cfg;
        logic xfer;
        logic [15:0] exp_d;
        k = 0;
        cyc = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        while (k < NW && cyc < 4000) begin
            cfg = 1'b0;
            if (mode == 1) begin
                ready_i = 1'($urandom_range(0, 1));
                cfg = ($urandom_range(0, 3) == 0);
                fc_rd_en_i = cfg;
                fc_rd_wr_bank_i = 2'd0;
                fc_rd_wr_addr_i = 8'($urandom_range(0, NW - 1));
                start_i = ($urandom_range(0, 7) == 0);
            end else begin
                ready_i = 1'b1;
                fc_rd_en_i = 1'b0;
                start_i = 1'b0;
            end
            #1;
            check("stream_valid", {31'd0, valid_o}, {31'd0, !cfg});
            check("stream_busy", {31'd0, busy_o}, 32'd1);
            if (valid_o) begin
                exp_d = {8'(0 - k), 8'(k)};
                check($sformatf("beat%0d_data", k), {16'd0, data_o}, {16'd0, exp_d});
                check($sformatf("beat%0d_last", k), {31'd0, last_o}, {31'd0, (k == NW - 1)});
            end
            xfer = valid_o && ready_i;
            @(negedge clk_i);
            cyc++;
            if (xfer) k++;
            if (stop_at >= 0 && k == stop_at) break;
        end
        start_i = 1'b0;
        fc_rd_en_i = 1'b0;
        if (cyc >= 4000) check("stream_timeout", 32'(k), 32'(NW));
        got = k;
    endtask

    initial begin
        int got;
        rst_n_i = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;
        cfg_idle();
        #1;
        check("rst_rd_data", fc_rd_data_o, 32'h0);
        check("rst_bias0", bias0_o, 32'h0);
        check("rst_bias1", bias1_o, 32'h0);
        check("rst_ctrl", {29'd0, busy_o, valid_o, last_o}, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        //            rd    wr    bank  addr     wdata          chk   exp_rd        b0             b1
        vq.push_back('{1'b0, 1'b1, 2'd0, 8'd5,   32'h000000F3, 1'b0, 32'h0,        32'h0,        32'h0});
        vq.push_back('{1'b1, 1'b0, 2'd0, 8'd5,   32'h0,        1'b1, 32'hFFFFFFF3, 32'h0,        32'h0});
        vq.push_back('{1'b0, 1'b1, 2'd2, 8'd0,   32'h12345678, 1'b0, 32'h0,        32'h12345678, 32'h0});
        vq.push_back('{1'b0, 1'b1, 2'd1, 8'd0,   32'h00000022, 1'b0, 32'h0,        32'h12345678, 32'h0});
        vq.push_back('{1'b0, 1'b1, 2'd1, 8'd208, 32'h0000007F, 1'b0, 32'h0,        32'h12345678, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'd1, 8'd0,   32'h0,        1'b1, 32'h00000022, 32'h12345678, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'd1, 8'd208, 32'h0,        1'b1, 32'h0,        32'h12345678, 32'h0});
        vq.push_back('{1'b0, 1'b1, 2'd3, 8'd1,   32'h0000DEAD, 1'b0, 32'h0,        32'h12345678, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'd3, 8'd1,   32'h0,        1'b1, 32'h0,        32'h12345678, 32'h0});
        vq.push_back('{1'b0, 1'b1, 2'd3, 8'd0,   32'hCAFEBABE, 1'b0, 32'h0,        32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b1, 1'b0, 2'd3, 8'd0,   32'h0,        1'b1, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b1, 1'b0, 2'd2, 8'd0,   32'h0,        1'b1, 32'h12345678, 32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b1, 1'b1, 2'd0, 8'd5,   32'h00000005, 1'b1, 32'hFFFFFFF3, 32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b1, 1'b0, 2'd0, 8'd5,   32'h0,        1'b1, 32'h00000005, 32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b0, 1'b0, 2'd0, 8'd0,   32'h0,        1'b1, 32'h00000005, 32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b0, 1'b1, 2'd0, 8'd6,   32'hAAAAAA80, 1'b0, 32'h0,        32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b1, 1'b0, 2'd0, 8'd6,   32'h0,        1'b1, 32'hFFFFFF80, 32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b0, 1'b1, 2'd2, 8'd1,   32'h0000FFFF, 1'b0, 32'h0,        32'h12345678, 32'hCAFEBABE});
        vq.push_back('{1'b1, 1'b0, 2'd2, 8'd1,   32'h0,        1'b1, 32'h0,        32'h12345678, 32'hCAFEBABE});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk_i);
            fc_rd_en_i = vq[i].rd;
            fc_wr_en_i = vq[i].wr;
            fc_rd_wr_bank_i = vq[i].bank;
            fc_rd_wr_addr_i = vq[i].addr;
            fc_wr_data_i = vq[i].wdata;
            @(posedge clk_i);
            #1;
            if (vq[i].chk_rd) check($sformatf("vec%0d_rd", i), fc_rd_data_o, vq[i].exp_rd);
            check($sformatf("vec%0d_bias0", i), bias0_o, vq[i].exp_b0);
            check($sformatf("vec%0d_bias1", i), bias1_o, vq[i].exp_b1);
            check($sformatf("vec%0d_idle", i), {30'd0, busy_o, valid_o}, 32'h0);
        end
        @(negedge clk_i);
        cfg_idle();

        // Load ramp patterns for the streaming tests.
        for (int i = 0; i < NW; i++) begin
            cfg_write(2'd0, 8'(i), 32'(i));
            cfg_write(2'd1, 8'(i), 32'(0 - i));
        end

        // Full stream, ready always high; busy must drop right after the last beat.
        run_stream(0, -1, got);
        #1;
        check("full_count", 32'(got), 32'(NW));
        check("full_busy_after", {31'd0, busy_o}, 32'd0);
        check("full_valid_after", {31'd0, valid_o}, 32'd0);

        // Backpressure, config stalls and ignored starts.
        run_stream(1, -1, got);
        #1;
        check("bp_count", 32'(got), 32'(NW));
        check("bp_busy_after", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset in the middle of the stream.
        run_stream(0, 100, got);
        check("rst_mid_count", 32'(got), 32'd100);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_bias0", bias0_o, 32'h0);
        check("rst_mid_rd", fc_rd_data_o, 32'h0);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            check("post_rst_no_beat", {30'd0, busy_o, valid_o}, 32'h0);
        end
        cfg_read_check("post_rst_w0", 2'd0, 8'd100, 32'd100);
        cfg_read_check("post_rst_w1", 2'd1, 8'd100, 32'hFFFFFF9C);
        run_stream(0, -1, got);
        #1;
        check("replay_count", 32'(got), 32'(NW));
        check("replay_busy_after", {31'd0, busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
